cal_pattern_sequencer: RTL and testbench
========================================

Name: cal_pattern_sequencer

Overview:
- Next-generation calibration sequencer for the LED strand.
- Steps the strand through a calibration pattern sequence in one of three modes: automatic one-LED-at-a-time sweep, automatic binary bit-plane (structured-light) sequence, or manual sweep.
- Answers per-LED colour requests from the strand driver and handshakes with the camera capture path so each pattern is captured only after it has been displayed for a settle period.
- Sits between the user controls, the LED strand driver and the camera frame-capture/calibration-table logic.

Parameters:
- NUM_LEDS, 50, LEDs on the strand.
- LED_ADDRESS_WIDTH, 6, LED index width; request port is LED_ADDRESS_WIDTH+1 bits.
- PLANE_BITS, $clog2(NUM_LEDS), bit planes in bit-plane mode.
- SETTLE_FRAMES, 2, strand refreshes (frame_shown pulses) between pattern change and capture request; range 1..15.
- ON_COLOR, 24'hFFFFFF, {green,red,blue} colour for lit LEDs.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begin sequence in mode selected by mode
- abort  in  1  pulse; terminate sequence
- mode  in  2  0=sweep, 1=bit-plane, 2=manual sweep, 3=reserved (treated as 0); sampled on start
- increment_id  in  1  pulse; manual mode step advance
- next_led_request  in  LED_ADDRESS_WIDTH+1  LED index requested by driver
- led_request_valid  in  1  next_led_request valid this cycle
- frame_shown  in  1  pulse; driver finished one full strand refresh
- capture_done  in  1  pulse; capture path stored the requested frame
- green_out, red_out, blue_out  out  8 each  colour for requested LED
- color_valid  out  1  colour outputs valid
- capture_req  out  1  level; request capture of current pattern
- step_index  out  LED_ADDRESS_WIDTH+1  current step number
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse; sequence completed normally

Behaviour:
- Reset: state IDLE; all outputs 0; step counter 0; settle counter 0.
- Colour lookup:
  - Response 1 cycle after led_request_valid=1 at index i; color_valid=1 for exactly that one cycle, otherwise 0.
  - Colour is ON_COLOR if LED i is lit in the current step, else 0.
  - i >= NUM_LEDS returns 0 with color_valid=1.
  - In IDLE and DONE all LEDs are unlit.
- Lit rules:
  - Sweep and manual: LED i lit iff i == step.
  - Bit-plane, step s, b = s>>1: if s even, LED i lit iff bit b of i is 1; if s odd, LED i lit iff bit b of i is 0.
- Step counts: sweep NUM_LEDS; bit-plane 2*PLANE_BITS; manual NUM_LEDS.
- States:
  - IDLE: busy=0. On start: latch mode, step=0, go SHOW.
  - SHOW: busy=1. Pattern for step is live. Settle counter cleared on entry and incremented per frame_shown. When it reaches SETTLE_FRAMES, go CAPTURE, or go HOLD in manual mode.
  - CAPTURE: capture_req=1 (level). capture_done while capture_req=1 goes NEXT and drops capture_req the following cycle. capture_done while capture_req=0 is ignored.
  - HOLD (manual only): waits for increment_id, then goes NEXT. capture_req stays 0.
  - NEXT: one cycle. If step == last step, go DONE; else step+1 and go SHOW.
  - DONE: done=1 for one cycle, step_index holds last step, then IDLE.
- Manual mode: increment_id pulses during SHOW are ignored. Only HOLD accepts them.
- Simultaneous events:
  - abort has priority over every other input. From any non-IDLE state the next state is IDLE, capture_req=0 and busy=0 next cycle, and done is not pulsed.
  - start while busy is ignored. start and abort in the same cycle in IDLE: remain IDLE.
  - frame_shown in the same cycle as the SHOW entry is counted.
  - A colour request arriving in the cycle the step changes is answered with the pattern of the pre-change step.
- Reset mid-sequence: returns to IDLE in 1 cycle with all outputs 0.
- step_index reflects the step counter combinationally from the register; width LED_ADDRESS_WIDTH+1 with no wrap.

Test Plan:
- Reset values: rst high 3 cycles -> every output 0, busy=0; request idx 5 -> color_valid=1 next cycle, colour 0.
- Sweep, NUM_LEDS=50, SETTLE_FRAMES=2:
  - Stimulus: start, 2 frame_shown, then capture_done each time capture_req rises.
  - Required: 50 capture_req assertions with step_index 0..49; in step 7 only idx 7 returns FFFFFF.
  - After the 50th capture_done: done pulses once, then busy=0.
- Bit-plane, NUM_LEDS=50 (PLANE_BITS=6):
  - 12 steps complete.
  - Step 4 (b=2): idx 4 lit, idx 3 dark.
  - Step 5: idx 3 lit, idx 4 dark.
  - idx 60 always returns 0.
- Manual mode:
  - Stimulus: start mode=2.
  - Required: after settle, capture_req stays 0 and step holds without increment_id.
  - increment_id in SHOW is ignored; increment_id in HOLD advances.
  - 50 increments produce done.
- Abort and capture_done timing:
  - abort during CAPTURE at step 10 -> capture_req=0 next cycle, IDLE, no done.
  - start in the same cycle as the abort -> ignored.
  - capture_done pulsed while in SHOW -> no advance.
- Request boundaries: led_request_valid at idx 49 and at idx 50 in back-to-back cycles -> two consecutive color_valid cycles with correct colours; request in the step-change cycle returns the old pattern.

Source files
------------

// File: rtl/cal_pattern_sequencer.sv
// LED strand calibration sequencer: sweep, bit-plane and manual pattern modes,
// per-LED colour lookup for the strand driver and capture handshake with the camera path.
module cal_pattern_sequencer #(
  parameter int unsigned NUM_LEDS          = 50,
  parameter int unsigned LED_ADDRESS_WIDTH = 6,
  parameter int unsigned PLANE_BITS        = $clog2(NUM_LEDS),
  parameter int unsigned SETTLE_FRAMES     = 2,
  parameter logic [23:0] ON_COLOR          = 24'hFFFFFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [1:0]                   mode,
  input  logic                         increment_id,
  input  logic [LED_ADDRESS_WIDTH:0]   next_led_request,
  input  logic                         led_request_valid,
  input  logic                         frame_shown,
  input  logic                         capture_done,
  output logic [7:0]                   green_out,
  output logic [7:0]                   red_out,
  output logic [7:0]                   blue_out,
  output logic                         color_valid,
  output logic                         capture_req,
  output logic [LED_ADDRESS_WIDTH:0]   step_index,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned IDX_W    = LED_ADDRESS_WIDTH + 1;
  localparam int unsigned SETTLE_W = 4;

  localparam logic [1:0] MODE_SWEEP  = 2'd0;
  localparam logic [1:0] MODE_PLANE  = 2'd1;
  localparam logic [1:0] MODE_MANUAL = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    SHOW,
    CAPTURE,
    HOLD,
    NEXT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    step_q, step_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [1:0]          mode_q, mode_d;
  logic [IDX_W-1:0]    last_step_c;
  logic [IDX_W-1:0]    plane_c;
  logic                lit_c;

  assign step_index = step_q;

  // Final step number depends on the latched mode
  always_comb begin
    last_step_c = IDX_W'(NUM_LEDS - 1);
    if (mode_q == MODE_PLANE) begin
      last_step_c = IDX_W'(2 * PLANE_BITS - 1);
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    settle_d = settle_q;
    mode_d   = mode_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = (mode == 2'd3) ? MODE_SWEEP : mode;
          step_d   = '0;
          settle_d = '0;
          state_d  = SHOW;
        end
      end
      SHOW: begin
        settle_d = settle_q + SETTLE_W'(frame_shown);
        if (settle_d == SETTLE_W'(SETTLE_FRAMES)) begin
          state_d = (mode_q == MODE_MANUAL) ? HOLD : CAPTURE;
        end
      end
      CAPTURE: begin
        if (capture_done) state_d = NEXT;
      end
      HOLD: begin
        if (increment_id) state_d = NEXT;
      end
      NEXT: begin
        if (step_q == last_step_c) begin
          state_d = DONE;
        end else begin
          step_d   = step_q + IDX_W'(1);
          settle_d = '0;
          state_d  = SHOW;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      step_d   = step_q;
      settle_d = settle_q;
      mode_d   = mode_q;
    end
  end

  // Is the requested LED lit in the currently displayed step?
  always_comb begin
    lit_c   = 1'b0;
    plane_c = next_led_request >> (step_q >> 1);
    if (state_q != IDLE && state_q != DONE && next_led_request < IDX_W'(NUM_LEDS)) begin
      if (mode_q == MODE_PLANE) begin
        lit_c = plane_c[0] ^ step_q[0];
      end else begin
        lit_c = (next_led_request == step_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      settle_q    <= '0;
      mode_q      <= MODE_SWEEP;
      busy        <= 1'b0;
      capture_req <= 1'b0;
      done        <= 1'b0;
      color_valid <= 1'b0;
      green_out   <= 8'h00;
      red_out     <= 8'h00;
      blue_out    <= 8'h00;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      settle_q    <= settle_d;
      mode_q      <= mode_d;
      busy        <= (state_d != IDLE);
      capture_req <= (state_d == CAPTURE);
      done        <= (state_d == DONE);
      color_valid <= led_request_valid;
      {green_out, red_out, blue_out} <= (led_request_valid && lit_c) ? ON_COLOR : 24'h000000;
    end
  end

endmodule

// File: tb/tb_cal_pattern_sequencer.sv
// Directed bench for cal_pattern_sequencer: reset, sweep, bit-plane, manual,
// abort/capture timing and request boundary cases.
module tb_cal_pattern_sequencer;

  localparam int unsigned IDX_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             increment_id = 1'b0;
  logic [IDX_W-1:0] next_led_request = '0;
  logic             led_request_valid = 1'b0;
  logic             frame_shown = 1'b0;
  logic             capture_done = 1'b0;
  logic [7:0]       green_out, red_out, blue_out;
  logic             color_valid, capture_req, busy, done;
  logic [IDX_W-1:0] step_index;

  int checks = 0;
  int errors = 0;
  logic done_seen;

  cal_pattern_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .increment_id(increment_id), .next_led_request(next_led_request),
    .led_request_valid(led_request_valid), .frame_shown(frame_shown),
    .capture_done(capture_done), .green_out(green_out), .red_out(red_out),
    .blue_out(blue_out), .color_valid(color_valid), .capture_req(capture_req),
    .step_index(step_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_frame();
    frame_shown = 1'b1;
    tick();
    frame_shown = 1'b0;
  endtask

  task automatic pulse_capture_done();
    capture_done = 1'b1;
    tick();
    capture_done = 1'b0;
  endtask

  task automatic pulse_increment();
    increment_id = 1'b1;
    tick();
    increment_id = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One-cycle request; checks the registered response after the edge
  task automatic req_check(input string tag, input int idx, input logic [23:0] exp);
    led_request_valid = 1'b1;
    next_led_request  = IDX_W'(idx);
    tick();
    led_request_valid = 1'b0;
    chk(tag, {7'd0, color_valid, green_out, red_out, blue_out}, {7'd0, 1'b1, exp});
  endtask

  task automatic wait_cap(input string tag);
    int n = 0;
    while (capture_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk(tag, 32'(capture_req), 32'd1);
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_capreq", 32'(capture_req), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cvalid", 32'(color_valid), 0);
    chk("rst_step", 32'(step_index), 0);
    chk("rst_color", {8'd0, green_out, red_out, blue_out}, 0);
    rst = 1'b0;
    tick();
    req_check("idle_req5", 5, 24'h000000);
    tick();
    chk("cvalid_one_cycle", 32'(color_valid), 0);

    // Sweep mode
    do_start(2'd0);
    chk("sweep_busy", 32'(busy), 1);
    for (int s = 0; s < 50; s++) begin
      pulse_frame();
      pulse_frame();
      wait_cap("sweep_capreq");
      chk("sweep_step", 32'(step_index), s);
      if (s == 7) begin
        req_check("sweep7_idx7", 7, 24'hFFFFFF);
        req_check("sweep7_idx6", 6, 24'h000000);
        req_check("sweep7_idx8", 8, 24'h000000);
      end
      if (s == 49) begin
        led_request_valid = 1'b1;
        next_led_request  = 7'd49;
        tick();
        chk("b2b_idx49", {7'd0, color_valid, green_out, red_out, blue_out}, {7'd0, 1'b1, 24'hFFFFFF});
        next_led_request  = 7'd50;
        tick();
        led_request_valid = 1'b0;
        chk("b2b_idx50", {7'd0, color_valid, green_out, red_out, blue_out}, {7'd0, 1'b1, 24'h000000});
        tick();
        chk("b2b_after", 32'(color_valid), 0);
      end
      pulse_capture_done();
      chk("sweep_capreq_drop", 32'(capture_req), 0);
      tick();
    end
    chk("sweep_done", 32'(done), 1);
    chk("sweep_done_step", 32'(step_index), 49);
    tick();
    chk("sweep_done_once", 32'(done), 0);
    chk("sweep_idle", 32'(busy), 0);

    // Bit-plane mode: 12 steps
    do_start(2'd1);
    for (int s = 0; s < 12; s++) begin
      pulse_frame();
      pulse_frame();
      wait_cap("plane_capreq");
      chk("plane_step", 32'(step_index), s);
      req_check("plane_idx60", 60, 24'h000000);
      if (s == 0) begin
        req_check("plane0_idx1", 1, 24'hFFFFFF);
        req_check("plane0_idx2", 2, 24'h000000);
      end
      if (s == 4) begin
        req_check("plane4_idx4", 4, 24'hFFFFFF);
        req_check("plane4_idx3", 3, 24'h000000);
      end
      if (s == 5) begin
        req_check("plane5_idx3", 3, 24'hFFFFFF);
        req_check("plane5_idx4", 4, 24'h000000);
      end
      pulse_capture_done();
      tick();
    end
    chk("plane_done", 32'(done), 1);
    chk("plane_done_step", 32'(step_index), 11);
    tick();
    chk("plane_idle", 32'(busy), 0);

    // Manual mode
    do_start(2'd2);
    pulse_increment();
    pulse_frame();
    pulse_frame();
    chk("man_hold_capreq", 32'(capture_req), 0);
    chk("man_show_inc_ignored", 32'(step_index), 0);
    repeat (3) tick();
    chk("man_hold_step", 32'(step_index), 0);
    chk("man_hold_busy", 32'(busy), 1);
    chk("man_hold_capreq2", 32'(capture_req), 0);
    for (int s = 0; s < 50; s++) begin
      if (s > 0) begin
        pulse_frame();
        pulse_frame();
      end
      chk("man_step", 32'(step_index), s);
      pulse_increment();
      tick();
    end
    chk("man_done", 32'(done), 1);
    tick();
    chk("man_idle", 32'(busy), 0);

    // Abort during CAPTURE at step 10, with a simultaneous start
    do_start(2'd0);
    for (int s = 0; s < 10; s++) begin
      pulse_frame();
      pulse_frame();
      wait_cap("abort_pre_capreq");
      pulse_capture_done();
      tick();
    end
    pulse_frame();
    pulse_frame();
    wait_cap("abort_capreq");
    chk("abort_step", 32'(step_index), 10);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_capreq_drop", 32'(capture_req), 0);
    chk("abort_busy", 32'(busy), 0);
    done_seen = done;
    repeat (4) begin
      tick();
      done_seen = done_seen | done;
    end
    chk("abort_no_done", 32'(done_seen), 0);
    chk("abort_start_ignored", 32'(busy), 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("idle_start_abort", 32'(busy), 0);

    // capture_done in SHOW is ignored; request in step-change cycle sees old pattern
    do_start(2'd0);
    pulse_capture_done();
    pulse_frame();
    pulse_frame();
    wait_cap("show_capdone_capreq");
    chk("show_capdone_step", 32'(step_index), 0);
    tick();
    tick();
    chk("capreq_level", 32'(capture_req), 1);
    pulse_capture_done();
    req_check("stepchange_old", 0, 24'hFFFFFF);
    chk("stepchange_step", 32'(step_index), 1);
    req_check("new_idx0", 0, 24'h000000);
    req_check("new_idx1", 1, 24'hFFFFFF);

    // Reset mid-sequence
    pulse_frame();
    pulse_frame();
    wait_cap("midrst_capreq");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_capreq", 32'(capture_req), 0);
    chk("midrst_step", 32'(step_index), 0);
    chk("midrst_cvalid", 32'(color_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
